// File: rtl/multicycle_control.sv
// Multicycle control unit for the MIPS-subset datapath.
// Sequences FETCH/DECODE/EXEC/MEM/WB as a Moore FSM. It also handles memory
// wait handshaking with a timeout, traps illegal instructions and counts
// retired instructions.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   opcode, funct            IR fields (opcode is valid from DECODE onward)
//   mem_ready, alu_zero      memory completion, ALU zero flag
//   pc_write..reg_write      datapath control strobes/selects
//   state                    current FSM state encoding
//   trap_illegal/timeout     sticky trap causes
//   retired                  completed-instruction counter (wraps)
module multicycle_control #(
    parameter int unsigned TIMEOUT_CYCLES = 15,
    parameter int unsigned CNT_W          = 4,
    parameter int unsigned RET_W          = 32,
    parameter bit          ENABLE_MEM     = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             mem_ready,
    input  logic             alu_zero,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             ir_write,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             zero_ext,
    output logic [3:0]       alu_op,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic [3:0]       state,
    output logic             trap_illegal,
    output logic             trap_timeout,
    output logic [RET_W-1:0] retired
);

    typedef enum logic [3:0] {
        IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2, EXEC_R = 4'd3,
        EXEC_I = 4'd4, MEM_ADDR = 4'd5, MEM_RD = 4'd6, MEM_WR = 4'd7,
        WB_R = 4'd8, WB_I = 4'd9, WB_MEM = 4'd10, BRANCH = 4'd11,
        JUMP = 4'd12, TRAP = 4'd13
    } ctrlState_t;

    localparam logic [3:0] OP_NOP = 4'd0, OP_ADD = 4'd1, OP_ADDU = 4'd2,
                           OP_SUB = 4'd3, OP_SUBU = 4'd4, OP_AND = 4'd5,
                           OP_OR  = 4'd6, OP_XOR = 4'd7, OP_SLL = 4'd8,
                           OP_SRL = 4'd9, OP_SRA = 4'd10;

    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    ctrlState_t       stateQ, stateNext;
    logic [CNT_W-1:0] waitQ, waitNext;
    logic [RET_W-1:0] retiredQ;
    logic             trapIllegalQ, trapTimeoutQ;
    logic             retireNow, setTrapIllegal, setTrapTimeout;

    logic [3:0] rAluOp, iAluOp;
    logic       isRType, isImm, isLw, isSw, isBeq, isJ, iZeroExt;

    // Instruction decode; an unlisted funct maps to NOP and marks R-type illegal
    always_comb begin
        rAluOp = OP_NOP;
        unique case (funct)
            6'h20:   rAluOp = OP_ADD;
            6'h21:   rAluOp = OP_ADDU;
            6'h22:   rAluOp = OP_SUB;
            6'h23:   rAluOp = OP_SUBU;
            6'h24:   rAluOp = OP_AND;
            6'h25:   rAluOp = OP_OR;
            6'h26:   rAluOp = OP_XOR;
            6'h00:   rAluOp = OP_SLL;
            6'h02:   rAluOp = OP_SRL;
            6'h03:   rAluOp = OP_SRA;
            default: rAluOp = OP_NOP;
        endcase
        iAluOp   = OP_NOP;
        iZeroExt = 1'b0;
        unique case (opcode)
            6'h08:   iAluOp = OP_ADD;
            6'h09:   iAluOp = OP_ADDU;
            6'h0C:   begin iAluOp = OP_AND; iZeroExt = 1'b1; end
            6'h0D:   begin iAluOp = OP_OR;  iZeroExt = 1'b1; end
            6'h0E:   begin iAluOp = OP_XOR; iZeroExt = 1'b1; end
            default: iAluOp = OP_NOP;
        endcase
        isRType = (opcode == 6'h00) && (rAluOp != OP_NOP);
        isImm   = (iAluOp != OP_NOP);
        isLw    = ENABLE_MEM && (opcode == 6'h23);
        isSw    = ENABLE_MEM && (opcode == 6'h2B);
        isBeq   = (opcode == 6'h04);
        isJ     = (opcode == 6'h02);
    end

    // Next-state, wait counter and state-decoded outputs
    always_comb begin
        stateNext      = stateQ;
        waitNext       = '0;
        retireNow      = 1'b0;
        setTrapIllegal = 1'b0;
        setTrapTimeout = 1'b0;
        pc_write       = 1'b0;
        pc_src         = 2'b00;
        ir_write       = 1'b0;
        i_or_d         = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        alu_src_a      = 1'b0;
        alu_src_b      = 2'b00;
        zero_ext       = 1'b0;
        alu_op         = OP_NOP;
        reg_dst        = 1'b0;
        mem_to_reg     = 1'b0;
        reg_write      = 1'b0;

        unique case (stateQ)
            IDLE: stateNext = FETCH;
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_op    = OP_ADD;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                alu_op    = OP_ADD;
                if (isRType)           stateNext = EXEC_R;
                else if (isImm)        stateNext = EXEC_I;
                else if (isLw || isSw) stateNext = MEM_ADDR;
                else if (isBeq)        stateNext = BRANCH;
                else if (isJ)          stateNext = JUMP;
                else begin
                    stateNext      = TRAP;
                    setTrapIllegal = 1'b1;
                end
            end
            EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = rAluOp;
                stateNext = WB_R;
            end
            EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = iAluOp;
                zero_ext  = iZeroExt;
                stateNext = WB_I;
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = OP_ADD;
                stateNext = isLw ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            WB_R: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retireNow = 1'b1;
                stateNext = FETCH;
            end
            WB_I: begin
                reg_write = 1'b1;
                retireNow = 1'b1;
                stateNext = FETCH;
            end
            WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retireNow  = 1'b1;
                stateNext  = FETCH;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = OP_SUB;
                pc_src    = 2'b01;
                pc_write  = alu_zero;
                retireNow = 1'b1;
                stateNext = FETCH;
            end
            JUMP: begin
                pc_write  = 1'b1;
                pc_src    = 2'b10;
                retireNow = 1'b1;
                stateNext = FETCH;
            end
            TRAP: stateNext = TRAP;
            default: stateNext = IDLE;
        endcase

        // Shared memory-wait handling; ready always wins over the limit
        if (stateQ == FETCH || stateQ == MEM_RD || stateQ == MEM_WR) begin
            if (mem_ready) begin
                unique case (stateQ)
                    FETCH:   stateNext = DECODE;
                    MEM_RD:  stateNext = WB_MEM;
                    default: begin
                        stateNext = FETCH;
                        retireNow = 1'b1;
                    end
                endcase
            end else if (waitQ == WAIT_LIMIT) begin
                stateNext      = TRAP;
                setTrapTimeout = 1'b1;
            end else begin
                waitNext = waitQ + CNT_W'(1);
            end
        end
    end

    // State, counters and sticky trap flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ       <= IDLE;
            waitQ        <= '0;
            retiredQ     <= '0;
            trapIllegalQ <= 1'b0;
            trapTimeoutQ <= 1'b0;
        end else begin
            stateQ <= stateNext;
            waitQ  <= waitNext;
            if (retireNow)      retiredQ     <= retiredQ + RET_W'(1);
            if (setTrapIllegal) trapIllegalQ <= 1'b1;
            if (setTrapTimeout) trapTimeoutQ <= 1'b1;
        end
    end

    assign state        = stateQ;
    assign retired      = retiredQ;
    assign trap_illegal = trapIllegalQ;
    assign trap_timeout = trapTimeoutQ;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: the stimulus thread pushes the
// hand-computed per-cycle expectation, the monitor pops and compares it on the
// falling edge. A second instance with ENABLE_MEM=0 shares the stimulus.
module tb_multicycle_control;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic mem_ready = 1'b0;
    logic alu_zero = 1'b0;

    logic pc_write, ir_write, i_or_d, mem_read, mem_write, alu_src_a;
    logic zero_ext, reg_dst, mem_to_reg, reg_write, trap_illegal, trap_timeout;
    logic [1:0] pc_src, alu_src_b;
    logic [3:0] alu_op, state;
    logic [31:0] retired;

    logic nPcWrite, nIrWrite, nIOrD, nMemRead, nMemWrite, nAluSrcA;
    logic nZeroExt, nRegDst, nMemToReg, nRegWrite, nTrapIllegal, nTrapTimeout;
    logic [1:0] nPcSrc, nAluSrcB;
    logic [3:0] nAluOp, nState;
    logic [31:0] nRetired;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .mem_ready(mem_ready), .alu_zero(alu_zero),
        .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .zero_ext(zero_ext),
        .alu_op(alu_op), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .state(state), .trap_illegal(trap_illegal),
        .trap_timeout(trap_timeout), .retired(retired)
    );

    multicycle_control #(.ENABLE_MEM(1'b0)) dutNoMem (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .mem_ready(mem_ready), .alu_zero(alu_zero),
        .pc_write(nPcWrite), .pc_src(nPcSrc), .ir_write(nIrWrite),
        .i_or_d(nIOrD), .mem_read(nMemRead), .mem_write(nMemWrite),
        .alu_src_a(nAluSrcA), .alu_src_b(nAluSrcB), .zero_ext(nZeroExt),
        .alu_op(nAluOp), .reg_dst(nRegDst), .mem_to_reg(nMemToReg),
        .reg_write(nRegWrite), .state(nState), .trap_illegal(nTrapIllegal),
        .trap_timeout(nTrapTimeout), .retired(nRetired)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [3:0]  st;
        logic [17:0] ctrl;
        logic [31:0] ret;
        logic        ti;
        logic        tt;
        bit          altChk;
        logic [3:0]  altSt;
        logic        altTi;
    } exp_t;

    exp_t sbq[$];
    int checks = 0;
    int failures = 0;

    function automatic logic [17:0] mk(input logic pw, input logic [1:0] ps,
            input logic irw, input logic iod, input logic mr, input logic mw,
            input logic asa, input logic [1:0] asb, input logic ze,
            input logic [3:0] op, input logic rd, input logic m2r, input logic rw);
        return {pw, ps, irw, iod, mr, mw, asa, asb, ze, op, rd, m2r, rw};
    endfunction

    // Monitor: one expectation per falling edge
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            logic [17:0] act;
            e = sbq.pop_front();
            act = {pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write,
                   alu_src_a, alu_src_b, zero_ext, alu_op, reg_dst, mem_to_reg,
                   reg_write};
            checks++;
            if (state !== e.st || act !== e.ctrl || retired !== e.ret ||
                trap_illegal !== e.ti || trap_timeout !== e.tt) begin
                failures++;
                $display("FAIL %s: got state=%0d ctrl=%h ret=%0d ti=%b tt=%b, want state=%0d ctrl=%h ret=%0d ti=%b tt=%b",
                         e.tag, state, act, retired, trap_illegal, trap_timeout,
                         e.st, e.ctrl, e.ret, e.ti, e.tt);
            end
            if (e.altChk) begin
                checks++;
                if (nState !== e.altSt || nTrapIllegal !== e.altTi) begin
                    failures++;
                    $display("FAIL %s_nomem: got state=%0d ti=%b, want state=%0d ti=%b",
                             e.tag, nState, nTrapIllegal, e.altSt, e.altTi);
                end
            end
        end
    end

    task automatic push(input string tag, input logic [3:0] st, input logic [17:0] c,
                        input logic [31:0] r, input logic ti, input logic tt,
                        input bit ac, input logic [3:0] ast, input logic ati);
        exp_t e;
        e.tag = tag; e.st = st; e.ctrl = c; e.ret = r; e.ti = ti; e.tt = tt;
        e.altChk = ac; e.altSt = ast; e.altTi = ati;
        sbq.push_back(e);
    endtask

    // One clock of stimulus plus the expectation for that cycle
    task automatic cyc(input logic rdy, input logic z, input string tag,
                       input logic [3:0] st, input logic [17:0] c,
                       input logic [31:0] r, input logic ti, input logic tt);
        @(posedge clk);
        #1;
        mem_ready = rdy;
        alu_zero  = z;
        push(tag, st, c, r, ti, tt, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic setIr(input logic [5:0] op, input logic [5:0] fn);
        opcode = op;
        funct  = fn;
    endtask

    // Reset asserted mid-cycle (checked immediately), released after a posedge
    task automatic doReset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        push("reset_async", 4'd0, 18'd0, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mem_ready = 1'b1;
        push("reset_release", 4'd0, 18'd0, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    endtask

    logic [17:0] cFetchR, cFetchW, cDecode, cExAdd, cExSub, cExOri, cMemAddr;
    logic [17:0] cMemRd, cMemWr, cWbR, cWbI, cWbMem, cBr1, cBr0, cJump;

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, want finish before 100us");
        $fatal(1);
    end

    initial begin
        cFetchR  = mk(1, 2'b00, 1, 0, 1, 0, 0, 2'b01, 0, 4'd1, 0, 0, 0);
        cFetchW  = mk(0, 2'b00, 0, 0, 1, 0, 0, 2'b01, 0, 4'd1, 0, 0, 0);
        cDecode  = mk(0, 2'b00, 0, 0, 0, 0, 0, 2'b11, 0, 4'd1, 0, 0, 0);
        cExAdd   = mk(0, 2'b00, 0, 0, 0, 0, 1, 2'b00, 0, 4'd1, 0, 0, 0);
        cExSub   = mk(0, 2'b00, 0, 0, 0, 0, 1, 2'b00, 0, 4'd3, 0, 0, 0);
        cExOri   = mk(0, 2'b00, 0, 0, 0, 0, 1, 2'b10, 1, 4'd6, 0, 0, 0);
        cMemAddr = mk(0, 2'b00, 0, 0, 0, 0, 1, 2'b10, 0, 4'd1, 0, 0, 0);
        cMemRd   = mk(0, 2'b00, 0, 1, 1, 0, 0, 2'b00, 0, 4'd0, 0, 0, 0);
        cMemWr   = mk(0, 2'b00, 0, 1, 0, 1, 0, 2'b00, 0, 4'd0, 0, 0, 0);
        cWbR     = mk(0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 4'd0, 1, 0, 1);
        cWbI     = mk(0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 4'd0, 0, 0, 1);
        cWbMem   = mk(0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 4'd0, 0, 1, 1);
        cBr1     = mk(1, 2'b01, 0, 0, 0, 0, 1, 2'b00, 0, 4'd3, 0, 0, 0);
        cBr0     = mk(0, 2'b01, 0, 0, 0, 0, 1, 2'b00, 0, 4'd3, 0, 0, 0);
        cJump    = mk(1, 2'b10, 0, 0, 0, 0, 0, 2'b00, 0, 4'd0, 0, 0, 0);

        doReset();

        // add
        setIr(6'h00, 6'h20);
        cyc(1, 0, "add_fetch",  4'd1, cFetchR, 0, 0, 0);
        cyc(1, 0, "add_decode", 4'd2, cDecode, 0, 0, 0);
        cyc(1, 0, "add_exec",   4'd3, cExAdd,  0, 0, 0);
        cyc(1, 0, "add_wb",     4'd8, cWbR,    0, 0, 0);
        // ori
        setIr(6'h0D, 6'h00);
        cyc(1, 0, "ori_fetch",  4'd1, cFetchR, 1, 0, 0);
        cyc(1, 0, "ori_decode", 4'd2, cDecode, 1, 0, 0);
        cyc(1, 0, "ori_exec",   4'd4, cExOri,  1, 0, 0);
        cyc(1, 0, "ori_wb",     4'd9, cWbI,    1, 0, 0);
        // lw with three not-ready cycles; the no-mem instance traps on it
        setIr(6'h23, 6'h00);
        cyc(1, 0, "lw_fetch",   4'd1, cFetchR, 2, 0, 0);
        cyc(1, 0, "lw_decode",  4'd2, cDecode, 2, 0, 0);
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        push("lw_memaddr", 4'd5, cMemAddr, 2, 0, 0, 1'b1, 4'd13, 1'b1);
        for (int i = 0; i < 3; i++)
            cyc(0, 0, "lw_memrd_wait", 4'd6, cMemRd, 2, 0, 0);
        cyc(1, 0, "lw_memrd_ready", 4'd6, cMemRd, 2, 0, 0);
        cyc(1, 0, "lw_wbmem",       4'd10, cWbMem, 2, 0, 0);
        // sw
        setIr(6'h2B, 6'h00);
        cyc(1, 0, "sw_fetch",   4'd1, cFetchR,  3, 0, 0);
        cyc(1, 0, "sw_decode",  4'd2, cDecode,  3, 0, 0);
        cyc(1, 0, "sw_memaddr", 4'd5, cMemAddr, 3, 0, 0);
        cyc(1, 0, "sw_memwr",   4'd7, cMemWr,   3, 0, 0);
        // beq taken then not taken
        setIr(6'h04, 6'h00);
        cyc(1, 0, "beq1_fetch",  4'd1, cFetchR, 4, 0, 0);
        cyc(1, 0, "beq1_decode", 4'd2, cDecode, 4, 0, 0);
        cyc(1, 1, "beq1_branch", 4'd11, cBr1,   4, 0, 0);
        cyc(1, 0, "beq0_fetch",  4'd1, cFetchR, 5, 0, 0);
        cyc(1, 0, "beq0_decode", 4'd2, cDecode, 5, 0, 0);
        cyc(1, 0, "beq0_branch", 4'd11, cBr0,   5, 0, 0);
        // j
        setIr(6'h02, 6'h00);
        cyc(1, 0, "j_fetch",  4'd1, cFetchR, 6, 0, 0);
        cyc(1, 0, "j_decode", 4'd2, cDecode, 6, 0, 0);
        cyc(1, 0, "j_jump",   4'd12, cJump,  6, 0, 0);
        // add abandoned by reset in EXEC_R
        setIr(6'h00, 6'h20);
        cyc(1, 0, "add2_fetch",  4'd1, cFetchR, 7, 0, 0);
        cyc(1, 0, "add2_decode", 4'd2, cDecode, 7, 0, 0);
        cyc(1, 0, "add2_exec",   4'd3, cExAdd,  7, 0, 0);
        doReset();
        // sub after 14 not-ready fetch cycles: ready at the limit wins
        setIr(6'h00, 6'h22);
        for (int i = 0; i < 14; i++)
            cyc(0, 0, "sub_fetch_wait", 4'd1, cFetchW, 0, 0, 0);
        cyc(1, 0, "sub_fetch_ready", 4'd1, cFetchR, 0, 0, 0);
        cyc(1, 0, "sub_decode",      4'd2, cDecode, 0, 0, 0);
        cyc(1, 0, "sub_exec",        4'd3, cExSub,  0, 0, 0);
        cyc(1, 0, "sub_wb",          4'd8, cWbR,    0, 0, 0);
        // illegal opcode 0x3F
        setIr(6'h3F, 6'h00);
        cyc(1, 0, "ill_fetch",  4'd1, cFetchR, 1, 0, 0);
        cyc(1, 0, "ill_decode", 4'd2, cDecode, 1, 0, 0);
        for (int i = 0; i < 20; i++)
            cyc(1, 1, "ill_trap", 4'd13, 18'd0, 1, 1, 0);
        doReset();
        // illegal R-type funct 0x27
        setIr(6'h00, 6'h27);
        cyc(1, 0, "illf_fetch",  4'd1, cFetchR, 0, 0, 0);
        cyc(1, 0, "illf_decode", 4'd2, cDecode, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            cyc(1, 0, "illf_trap", 4'd13, 18'd0, 0, 1, 0);
        doReset();
        // fetch timeout after 15 not-ready cycles
        setIr(6'h00, 6'h20);
        for (int i = 0; i < 15; i++)
            cyc(0, 0, "to_fetch_wait", 4'd1, cFetchW, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            cyc(1, 0, "to_trap", 4'd13, 18'd0, 0, 0, 1);

        @(negedge clk);
        #1;
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: got %0d pending, want 0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle control unit for the MIPS subset datapath. It replaces the single-cycle main/ALU decode pair with a registered Moore state machine that sequences fetch, decode, execute, memory and write-back. It adds load/store, beq and j, memory wait handshaking with a timeout, illegal-instruction trapping and a retired-instruction counter. It sits between the instruction register fields and the shared datapath (PC, memory, register file, ALU).

## Interface
- `TIMEOUT_CYCLES`, default 15: maximum consecutive not-ready cycles tolerated in one memory state; must be ≥1 and < 2^`CNT_W`.
- `CNT_W`, default 4: width of the memory-wait counter.
- `RET_W`, default 32: width of the retired-instruction counter.
- `ENABLE_MEM`, default 1: when 0, lw/sw decode as illegal.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `opcode`  in  6  IR[31:26]; valid from DECODE onward.
- `funct`  in  6  IR[5:0].
- `mem_ready`  in  1  memory completes the current access this cycle.
- `alu_zero`  in  1  ALU zero flag.
- `pc_write`  out  1  PC load strobe.
- `pc_src`  out  2  PC source: 00 ALU result, 01 ALUOut register, 10 jump target.
- `ir_write`  out  1  IR load strobe.
- `i_or_d`  out  1  memory address source: 0 PC, 1 ALUOut.
- `mem_read`, `mem_write`  out  1 each  memory strobes.
- `alu_src_a`  out  1  ALU A source: 0 PC, 1 register A.
- `alu_src_b`  out  2  ALU B source: 00 register B, 01 constant 4, 10 extended immediate, 11 sign-extended immediate<<2.
- `zero_ext`  out  1  immediate is zero-extended (andi/ori/xori).
- `alu_op`  out  4  ALU op: NOP 0, ADD 1, ADDU 2, SUB 3, SUBU 4, AND 5, OR 6, XOR 7, SLL 8, SRL 9, SRA 10.
- `reg_dst`  out  1  write register: 1 rd, 0 rt.
- `mem_to_reg`  out  1  write-back source is MDR.
- `reg_write`  out  1  register-file write strobe.
- `state`  out  4  current state encoding.
- `trap_illegal`, `trap_timeout`  out  1 each  sticky trap causes.
- `retired`  out  `RET_W`  completed-instruction count; wraps modulo 2^`RET_W`.

## Operation
- **Decode set.** R-type is opcode 0x00 with these functs: add 0x20, addu 0x21, sub 0x22, subu 0x23, and 0x24, or 0x25, xor 0x26, sll 0x00, srl 0x02, sra 0x03. Immediates: addi 0x08 (ADD), addiu 0x09 (ADDU), andi 0x0C (AND), ori 0x0D (OR), xori 0x0E (XOR). Also lw 0x23, sw 0x2B, beq 0x04, j 0x02. Any other opcode, or an unlisted R-type funct, is illegal.
- **Moore outputs.** All control outputs are a function of `state` only. The exceptions are `pc_write` in BRANCH and the ready-qualified strobes in FETCH.
- **States and outputs.** Any output not listed for a state is 0.
  - IDLE 0: all outputs 0. Next state is FETCH.
  - FETCH 1: `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=ADD, `pc_src`=00. `ir_write` and `pc_write` equal `mem_ready`. Stays in FETCH until `mem_ready`, then goes to DECODE.
  - DECODE 2: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=ADD (precomputes the branch target). Next state:
    - R-type → EXEC_R
    - immediate → EXEC_I
    - lw/sw → MEM_ADDR
    - beq → BRANCH
    - j → JUMP
    - illegal → TRAP
  - EXEC_R 3: `alu_src_a`=1, `alu_src_b`=00, `alu_op` from funct. Next state is WB_R.
  - EXEC_I 4: `alu_src_a`=1, `alu_src_b`=10, `alu_op` from opcode; `zero_ext`=1 for andi/ori/xori. Next state is WB_I.
  - MEM_ADDR 5: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=ADD. Next state is MEM_RD for lw, MEM_WR for sw.
  - MEM_RD 6: `mem_read`=1, `i_or_d`=1. Waits for `mem_ready`, then goes to WB_MEM.
  - MEM_WR 7: `mem_write`=1, `i_or_d`=1. Waits for `mem_ready`, then retires and goes to FETCH.
  - WB_R 8: `reg_write`=1, `reg_dst`=1. Retires, then goes to FETCH.
  - WB_I 9: `reg_write`=1, `reg_dst`=0. Retires, then goes to FETCH.
  - WB_MEM 10: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0. Retires, then goes to FETCH.
  - BRANCH 11: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=SUB, `pc_src`=01, `pc_write`=`alu_zero`. Retires, then goes to FETCH.
  - JUMP 12: `pc_write`=1, `pc_src`=10. Retires, then goes to FETCH.
  - TRAP 13: all strobes 0. Absorbing until reset.
- **Wait counter.**
  - Clears on entry to FETCH, MEM_RD and MEM_WR, and whenever `mem_ready`=1.
  - Increments on each cycle spent in one of those states with `mem_ready`=0.
  - When a not-ready cycle occurs with the counter at `TIMEOUT_CYCLES`-1, the next state is TRAP and `trap_timeout` sets.
- **Retirement.** "Retires" means `retired` increments by 1 on that state's exit edge.
- **Trap flags.** `trap_illegal` sets on the DECODE→TRAP edge. Both trap flags stay set until reset.

## Timing
- **Reset.** `rst_n` low asynchronously forces `state`=IDLE, counters=0 and trap flags=0. As a result, every output reads 0 during reset. Reset mid-instruction abandons it with no retirement.
- **Cycle counts** with `mem_ready` tied high:
  - R-type and immediate: 4 cycles (FETCH, DECODE, EXEC, WB).
  - lw: 5 cycles; sw: 4 cycles.
  - beq and j: 3 cycles.
  - Each not-ready cycle adds 1.
- **Simultaneous timeout and ready.** `mem_ready`=1 on the cycle the counter is at its limit completes normally; ready wins.
- **`alu_zero`** is sampled only in BRANCH, combinationally, in that same cycle.

## Test plan
- **Reset:** `rst_n` pulsed low mid-EXEC_R → `state`=0, all strobes 0, `retired`=0 immediately; FETCH on the second edge after release.
- **R-type and immediate, `mem_ready`=1:**
  - add (funct 0x20) → state sequence 1,2,3,8; `alu_op`=1 in EXEC_R; `reg_write`=1 with `reg_dst`=1 in WB_R; `retired`=1.
  - ori → `zero_ext`=1 and `alu_op`=6 in EXEC_I.
- **lw with 3 not-ready cycles in MEM_RD:** → 8 cycles total; `mem_to_reg`=1 in WB_MEM.
- **beq:**
  - `alu_zero`=1 → `pc_write`=1 with `pc_src`=01.
  - `alu_zero`=0 → `pc_write`=0; `retired` still increments.
- **Illegal:**
  - opcode 0x3F → TRAP after DECODE; `trap_illegal`=1; no further strobes for 20 cycles.
  - funct 0x27 → same trap behaviour.
  - `ENABLE_MEM`=0 with lw → trap.
- **Timeout:** `mem_ready`=0 for 15 FETCH cycles → TRAP, `trap_timeout`=1. A run of 14 not-ready cycles followed by ready → no trap.
